id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the 3-stage RV32I core. It sits directly downstream of the control decoder and registers the 16-bit control word, PC, instruction and operand data into EX. It also detects load-use hazards, inserting a bubble and stalling fetch/decode. Branch/jump redirects and downstream stalls are handled here, and the block keeps a bubble counter for performance monitoring.

Parameters:
XLEN, 32, datapath width of PC and operands
CTRL_W, 16, control word width
NOP_INST, 32'h0000_0013, instruction word used for bubbles and reset (addi x0,x0,0)

Ports:
clk_i  input  1  core clock; all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
id_valid_i  input  1  ID holds a real instruction
id_inst_i  input  32  ID instruction word; opcode, rd, rs1 and rs2 fields are used
id_pc_i  input  XLEN  ID instruction PC
id_ctrl_i  input  CTRL_W  control word from the decoder
id_rs1_data_i  input  XLEN  regfile read port 1
id_rs2_data_i  input  XLEN  regfile read port 2
ex_stall_i  input  1  EX/MEM not ready (data-memory wait); freezes this stage
flush_i  input  1  redirect resolved in EX; squash the ID instruction
stall_o  output  1  hold PC and the IF/ID register this cycle
ex_valid_o  output  1  EX holds a real instruction
ex_inst_o  output  32  registered instruction
ex_pc_o  output  XLEN  registered PC
ex_ctrl_o  output  CTRL_W  registered control word
ex_rs1_data_o  output  XLEN  registered operand 1
ex_rs2_data_o  output  XLEN  registered operand 2
bubble_cnt_o  output  32  count of bubbles inserted

Behaviour:
- Control-word fields used here: bit0 RegWEn; bits[13:12] WBSel, where 00 means memory.
- ex_is_load = ex_valid_o & ex_ctrl_o[0] & (ex_ctrl_o[13:12]==2'b00).
- Register usage is decoded from id_inst_i[6:0]:
  - uses_rs1: all opcodes except LUI, AUIPC and JAL.
  - uses_rs2: R-type, STORE and BRANCH.
- Hazard condition: hazard = id_valid_i & ex_is_load & (ex rd != 0) & ((uses_rs1 & rs1==ex rd) | (uses_rs2 & rs2==ex rd)). ex rd = ex_inst_o[11:7].
- Per-edge priority:
  1. rst_i: asynchronous; takes effect immediately, not on an edge.
  2. ex_stall_i: all EX registers hold, counter holds, flush_i is ignored. Upstream keeps flush_i asserted until the stall clears.
  3. flush_i: load a bubble.
  4. hazard: load a bubble.
  5. Otherwise load the ID inputs. ex_valid_o = id_valid_i. When id_valid_i=0, ctrl is zeroed and inst = NOP_INST.
- Bubble contents: ex_valid_o=0, ex_ctrl_o=0, ex_inst_o=NOP_INST, ex_pc_o=id_pc_i, operand registers = 0.
- stall_o is combinational: stall_o = ex_stall_i | (hazard & ~flush_i). Flush overrides hazard because the ID instruction is dead.
- Load-use latency: exactly one bubble per load-use pair. After the bubble, EX no longer holds the load, so the hazard drops and ID advances on the next edge.
- bubble_cnt_o increments by 1 on each edge where a bubble is loaded for a valid ID instruction due to hazard or flush. It saturates at 32'hFFFF_FFFF; no wrap.
- Reset values:
  - ex_valid_o=0, ex_ctrl_o=0, ex_inst_o=NOP_INST, ex_pc_o=0.
  - Operand registers=0, bubble_cnt_o=0.
  - stall_o follows its combinational equation, so it is 0 unless ex_stall_i=1.
- Reset mid-stall clears EX immediately. The first edge after deassertion is a normal edge.
- rd=x0 loads never cause a hazard. A store's rs2 matching a load rd does cause a hazard; no special-casing.

Test Plan:
- Normal flow: ADD x3,x1,x2 at pc 0x100 with ctrl 16'h1001 → next edge ex_valid_o=1, ex_ctrl_o=16'h1001, ex_pc_o=0x100, stall_o=0.
- Load-use: LW x5 in EX (ctrl 16'h0041), ID = ADD x6,x5,x1 → stall_o=1. Next edge ex_valid_o=0 and ex_ctrl_o=0. The edge after, the ADD enters EX. bubble_cnt_o=1.
- No false hazard: LW x0 in EX, ID reads x0 → stall_o=0. Separately, LUI x5 after LW x5 → no stall.
- Flush beats hazard: hazard and flush_i in the same cycle → stall_o=0, bubble loaded, bubble_cnt_o increments by 1.
- ex_stall_i=1 for 3 cycles with flush_i high → EX outputs and counter frozen, stall_o=1. Flush takes effect on the first edge after ex_stall_i drops.
- Async reset asserted mid-stall between clock edges → outputs show reset values before the next edge. With the counter preloaded near saturation, it holds at 32'hFFFF_FFFF and does not wrap.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 3-stage RV32I core: load-use hazard
// detection, bubble insertion on flush/hazard, and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          CTRL_W   = 16,
  parameter logic [31:0]          NOP_INST = 32'h0000_0013,
  parameter logic [31:0]          CNT_INIT = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_inst_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [31:0]       ex_inst_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [31:0]       bubble_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic              ex_valid_reg;
  logic [31:0]       ex_inst_reg;
  logic [XLEN-1:0]   ex_pc_reg;
  logic [CTRL_W-1:0] ex_ctrl_reg;
  logic [XLEN-1:0]   ex_rs1_data_reg;
  logic [XLEN-1:0]   ex_rs2_data_reg;
  logic [31:0]       bubble_cnt_reg;

  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       hazard;
  logic       load_bubble;
  logic       count_bubble;

  always_comb begin
    id_opcode  = id_inst_i[6:0];
    id_rs1     = id_inst_i[19:15];
    id_rs2     = id_inst_i[24:20];
    ex_rd      = ex_inst_reg[11:7];
    ex_is_load = ex_valid_reg & ex_ctrl_reg[0] & (ex_ctrl_reg[13:12] == 2'b00);
    uses_rs1   = (id_opcode != OP_LUI) & (id_opcode != OP_AUIPC) & (id_opcode != OP_JAL);
    uses_rs2   = (id_opcode == OP_RTYPE) | (id_opcode == OP_STORE) | (id_opcode == OP_BRANCH);
    hazard     = id_valid_i & ex_is_load & (ex_rd != 5'd0) &
                 ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
    // A flushed ID instruction is dead, so its hazard must not hold fetch.
    stall_o      = ex_stall_i | (hazard & ~flush_i);
    load_bubble  = flush_i | hazard;
    count_bubble = load_bubble & id_valid_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_reg    <= 1'b0;
      ex_inst_reg     <= NOP_INST;
      ex_pc_reg       <= '0;
      ex_ctrl_reg     <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      bubble_cnt_reg  <= CNT_INIT;
    end else if (!ex_stall_i) begin
      if (load_bubble) begin
        ex_valid_reg    <= 1'b0;
        ex_inst_reg     <= NOP_INST;
        ex_pc_reg       <= id_pc_i;
        ex_ctrl_reg     <= '0;
        ex_rs1_data_reg <= '0;
        ex_rs2_data_reg <= '0;
      end else begin
        ex_valid_reg    <= id_valid_i;
        ex_inst_reg     <= id_valid_i ? id_inst_i : NOP_INST;
        ex_pc_reg       <= id_pc_i;
        ex_ctrl_reg     <= id_valid_i ? id_ctrl_i : '0;
        ex_rs1_data_reg <= id_rs1_data_i;
        ex_rs2_data_reg <= id_rs2_data_i;
      end
      if (count_bubble && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign ex_valid_o    = ex_valid_reg;
  assign ex_inst_o     = ex_inst_reg;
  assign ex_pc_o       = ex_pc_reg;
  assign ex_ctrl_o     = ex_ctrl_reg;
  assign ex_rs1_data_o = ex_rs1_data_reg;
  assign ex_rs2_data_o = ex_rs2_data_reg;
  assign bubble_cnt_o  = bubble_cnt_reg;

endmodule
